apb_master_xfer: RTL and testbench

APB_MASTER_XFER -- requirements
Module: apb_master_xfer

---
 rtl/apb_master_xfer.sv | 136 +++++++++++++
 tb/tb_apb_master_xfer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_xfer.sv
// apb_master_xfer: turns granted packets into APB transfers (IDLE/SETUP/ACCESS)
// and queues each completion in a 4-entry response FIFO.
// Optional: define APB_TIMEOUT_EN to force completion (err=1) after 16 stalled
// ACCESS cycles; without it ACCESS waits for pready indefinitely.
module apb_master_xfer (
    input  logic        clk,
    input  logic        reset,
    input  logic        pkt_valid,
    input  logic [31:0] pkt_wdata,
    input  logic [31:0] pkt_addr,
    input  logic        pkt_write,
    output logic        pkt_ready,
    output logic        psel,
    output logic        penable,
    output logic        pwrite,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    input  logic [31:0] prdata,
    input  logic        pready,
    input  logic        pslverr,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_write,
    output logic        rsp_err,
    input  logic        rsp_ready
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

    state_t      r_state;
    logic        r_psel, r_penable, r_pwrite;
    logic [31:0] r_paddr, r_pwdata;
    logic [1:0]  r_wptr, r_rptr;
    logic [2:0]  r_count;
    logic [33:0] r_mem [4];

    logic        w_accept, w_pop, w_push, w_done, w_tmo;
    logic [33:0] w_entry;

`ifdef APB_TIMEOUT_EN
    logic [4:0]  r_tcnt;
    // 16th consecutive stalled ACCESS cycle ends the transfer
    assign w_tmo = !pready && (r_tcnt == 5'd15);
`else
    assign w_tmo = 1'b0;
`endif

    assign rsp_valid = (r_count != 3'd0);
    // a full queue may still accept when the head is popped this same cycle
    assign pkt_ready = (r_state == S_IDLE) && !reset &&
                       ((r_count < 3'd4) || rsp_ready);
    assign w_accept  = pkt_valid && pkt_ready;
    assign w_pop     = rsp_valid && rsp_ready;
    assign w_done    = (r_state == S_ACCESS) && (pready || w_tmo);
    assign w_push    = w_done && !reset;
    assign w_entry   = {(r_pwrite || w_tmo) ? 32'h0 : prdata, r_pwrite, pslverr || w_tmo};

    assign psel      = r_psel;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;
    assign rsp_rdata = r_mem[r_rptr][33:2];
    assign rsp_write = r_mem[r_rptr][1];
    assign rsp_err   = r_mem[r_rptr][0];

    // transfer FSM with registered APB request outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= 32'h0;
            r_pwdata  <= 32'h0;
`ifdef APB_TIMEOUT_EN
            r_tcnt    <= 5'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_paddr  <= pkt_addr;
                        r_pwdata <= pkt_wdata;
                        r_pwrite <= pkt_write;
                        r_psel   <= 1'b1;
                        r_state  <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= S_ACCESS;
`ifdef APB_TIMEOUT_EN
                    r_tcnt    <= 5'd0;
`endif
                end
                S_ACCESS: begin
                    if (w_done) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_state   <= S_IDLE;
                    end
`ifdef APB_TIMEOUT_EN
                    else begin
                        r_tcnt <= r_tcnt + 5'd1;
                    end
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // response queue pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= 2'd0;
            r_rptr  <= 2'd0;
            r_count <= 3'd0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 2'd1;
            if (w_pop)  r_rptr <= r_rptr + 2'd1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // response storage, not reset (contents only visible while rsp_valid)
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= w_entry;
    end

endmodule

// File: tb/tb_apb_master_xfer.sv
// Self-checking bench for apb_master_xfer: directed spec scenarios plus a
// randomized phase, responses checked against a scoreboard of expected entries.
module tb_apb_master_xfer;

    logic        clk = 1'b0;
    logic        reset;
    logic        pkt_valid, pkt_write, pkt_ready;
    logic [31:0] pkt_wdata, pkt_addr;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata, prdata;
    logic        pready, pslverr;
    logic        rsp_valid, rsp_write, rsp_err, rsp_ready;
    logic [31:0] rsp_rdata;

    int          n_cmp = 0;
    int          n_err = 0;
    bit          rnd_rdy = 0;
    logic [33:0] sb [$];

    apb_master_xfer dut (
        .clk(clk), .reset(reset),
        .pkt_valid(pkt_valid), .pkt_wdata(pkt_wdata), .pkt_addr(pkt_addr),
        .pkt_write(pkt_write), .pkt_ready(pkt_ready),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_write(rsp_write),
        .rsp_err(rsp_err), .rsp_ready(rsp_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge; all inputs are driven here
    task automatic cyc();
        @(posedge clk);
        #1;
        if (rnd_rdy) rsp_ready = 1'($urandom);
    endtask

    // every popped response must match the oldest expected one
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL rsp_unexpected: observed %0h expected none", {rsp_rdata, rsp_write, rsp_err});
            end else begin
                chk("rsp", 80'({rsp_rdata, rsp_write, rsp_err}), 80'(sb.pop_front()));
            end
        end
    end

    // present a packet and wait (bounded) until it is accepted; ends at negedge
    task automatic xfer_acc(input logic [31:0] a, input logic [31:0] wd, input logic w);
        int t;
        t = 0;
        pkt_addr = a; pkt_wdata = wd; pkt_write = w; pkt_valid = 1'b1;
        @(negedge clk);
        while (!pkt_ready && t < 200) begin
            cyc();
            @(negedge clk);
            t++;
        end
        chk("accept", 80'(pkt_ready), 80'(1'b1));
        chk("idle_bus", 80'({psel, penable}), 80'(2'b00));
    endtask

    // SETUP + ACCESS with 'waits' stalled cycles; ends just after completing edge
    task automatic xfer_rest(input logic [31:0] a, input logic [31:0] wd, input logic w,
                             input int waits, input logic [31:0] rd, input logic er);
        cyc();
        pkt_valid = 1'b0;
        pkt_addr = $urandom; pkt_wdata = $urandom; pkt_write = 1'($urandom);
        pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
        @(negedge clk);
        chk("setup", 80'({psel, penable, pwrite, paddr, pwdata}), 80'({2'b10, w, a, wd}));
        for (int i = 0; i <= waits; i++) begin
            cyc();
            if (i == waits) begin
                pready = 1'b1; prdata = rd; pslverr = er;
                sb.push_back({w ? 32'h0 : rd, w, er});
            end else begin
                pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom);
            end
            @(negedge clk);
            chk("access", 80'({psel, penable, pwrite, paddr, pwdata}), 80'({2'b11, w, a, wd}));
        end
        cyc();
        pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
    endtask

    task automatic xfer(input logic [31:0] a, input logic [31:0] wd, input logic w,
                        input int waits, input logic [31:0] rd, input logic er);
        xfer_acc(a, wd, w);
        xfer_rest(a, wd, w, waits, rd, er);
    endtask

    task automatic drain();
        int t;
        t = 0;
        rnd_rdy = 0;
        rsp_ready = 1'b1;
        @(negedge clk);
        while (rsp_valid && t < 50) begin
            cyc();
            @(negedge clk);
            t++;
        end
        chk("drain_empty", 80'(rsp_valid), 80'(1'b0));
        chk("sb_empty", 80'(sb.size()), 80'(0));
        chk("drain_idle", 80'({psel, penable}), 80'(2'b00));
        cyc();
    endtask

    initial begin
        int n;
        logic [31:0] a, wd, rd;
        logic w, er;
        reset = 1'b1; pkt_valid = 1'b0; pkt_write = 1'b0; pkt_addr = '0; pkt_wdata = '0;
        pready = 1'b0; prdata = '0; pslverr = 1'b0; rsp_ready = 1'b0;
        cyc(); cyc();
        @(negedge clk);
        chk("rst_bus", 80'({psel, penable, pwrite, paddr, pwdata}), 80'(0));
        chk("rst_rsp_valid", 80'(rsp_valid), 80'(1'b0));
        chk("rst_pkt_ready", 80'(pkt_ready), 80'(1'b0));
        cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("idle_pkt_ready", 80'(pkt_ready), 80'(1'b1));
        cyc();

        // single write, response visible one cycle after ACCESS
        xfer(32'h10, 32'hDEADBEEF, 1'b1, 0, 32'hFFFF_FFFF, 1'b0);
        @(negedge clk);
        chk("wr_rsp", 80'({rsp_valid, rsp_rdata, rsp_write, rsp_err}), 80'({1'b1, 32'h0, 1'b1, 1'b0}));
        cyc();
        drain();

        // read with three wait states
        xfer(32'h20, 32'h5555_AAAA, 1'b0, 3, 32'h12345678, 1'b0);
        drain();

        // queue full: four queued, fifth held until one pop
        rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) xfer(32'h100 + 32'(k), $urandom, 1'b0, 0, $urandom, 1'b0);
        pkt_addr = 32'h200; pkt_wdata = 32'hCAFE0005; pkt_write = 1'b1; pkt_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("full_block", 80'({pkt_ready, rsp_valid}), 80'(2'b01));
            cyc();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("full_pop_accept", 80'(pkt_ready), 80'(1'b1));
        xfer_rest(32'h200, 32'hCAFE0005, 1'b1, 1, 32'h0, 1'b0);
        drain();

        // six reads, third with slave error, pointers wrap
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++)
            xfer(32'h300 + 32'(4 * k), 32'h0, 1'b0, $urandom_range(0, 2), $urandom, (k == 2));
        drain();

        // randomized traffic with random response back-pressure
        rnd_rdy = 1;
        for (int k = 0; k < 24; k++) begin
            a = $urandom; wd = $urandom; rd = $urandom;
            w = 1'($urandom); er = ($urandom_range(0, 3) == 0);
            xfer(a, wd, w, $urandom_range(0, 3), rd, er);
        end
        drain();

        // reset while in ACCESS: transfer dropped, nothing queued
        xfer_acc(32'h400, 32'h1, 1'b0);
        cyc(); pkt_valid = 1'b0;
        cyc();
        @(negedge clk);
        chk("pre_rst_access", 80'({psel, penable}), 80'(2'b11));
        cyc(); reset = 1'b1; pready = 1'b1;
        @(negedge clk);
        chk("rst_cycle_pkt_ready", 80'(pkt_ready), 80'(1'b0));
        cyc(); reset = 1'b0; pready = 1'b0;
        @(negedge clk);
        chk("post_rst", 80'({psel, penable, rsp_valid}), 80'(3'b000));
        cyc(); pready = 1'b1; pslverr = 1'b1;
        cyc(); cyc();
        @(negedge clk);
        chk("post_rst_noq", 80'({psel, rsp_valid}), 80'(2'b00));
        cyc(); pready = 1'b0; pslverr = 1'b0;

        // pready never arrives
        rsp_ready = 1'b1;
        xfer_acc(32'h500, 32'h0, 1'b0);
        cyc(); pkt_valid = 1'b0;
        prdata = 32'hBAD0BAD0;
`ifdef APB_TIMEOUT_EN
        sb.push_back({32'h0, 1'b0, 1'b1});
`endif
        cyc();
        n = 0;
        @(negedge clk);
        while (penable && n < 100) begin
            n++;
            cyc();
            @(negedge clk);
        end
`ifdef APB_TIMEOUT_EN
        chk("tmo_access_cycles", 80'(n), 80'(16));
        cyc();
        drain();
`else
        chk("stall_access_cycles", 80'(n), 80'(100));
        chk("stall_still_access", 80'({psel, penable}), 80'(2'b11));
        cyc();
`endif
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        @(negedge clk);
        chk("final_idle", 80'({psel, penable, rsp_valid, pkt_ready}), 80'(4'b0001));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
